// File: rtl/polyline_plotter.sv
// Polyline plotter: pulls NUM_POINTS signed Y samples per frame and hands successive
// segments (or single points) to a line drawer, clamping Y to the visible screen.
module polyline_plotter #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int X_STEP            = 8,
    parameter int Y_CENTER          = 240,
    parameter int SAMPLE_WIDTH      = 12,
    localparam int X_WIDTH    = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH    = $clog2(VER_ACTIVE_PIXELS),
    localparam int NUM_POINTS = (HOR_ACTIVE_PIXELS - 1) / X_STEP + 1,
    localparam int PT_WIDTH   = $clog2(NUM_POINTS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode_points,
    output logic                    ready,
    output logic                    clipped,
    output logic                    sample_ready,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic [X_WIDTH-1:0]      x1,
    output logic [Y_WIDTH-1:0]      y1,
    output logic [X_WIDTH-1:0]      x2,
    output logic [Y_WIDTH-1:0]      y2,
    output logic                    line_drawer_start,
    input  logic                    line_drawer_ready
);

    typedef enum logic [2:0] {IDLE, FETCH, DRAW, WAIT1, WAIT2} state_t;

    localparam int DW = SAMPLE_WIDTH + 2;
    localparam logic signed [DW-1:0]    Y_CENTER_S = DW'(Y_CENTER);
    localparam logic signed [DW-1:0]    Y_MAX_S    = DW'(VER_ACTIVE_PIXELS - 1);
    localparam logic [Y_WIDTH-1:0]      Y_MAX      = Y_WIDTH'(VER_ACTIVE_PIXELS - 1);
    localparam logic [X_WIDTH-1:0]      X_INC      = X_WIDTH'(X_STEP);
    localparam logic [PT_WIDTH-1:0]     K_LAST     = PT_WIDTH'(NUM_POINTS - 1);
    localparam logic [PT_WIDTH-1:0]     K_ONE      = PT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [PT_WIDTH-1:0]  k_q, k_d;
    logic [X_WIDTH-1:0]   xacc_q, xacc_d;
    logic [X_WIDTH-1:0]   x1_q, x1_d, x2_q, x2_d;
    logic [Y_WIDTH-1:0]   y1_q, y1_d, y2_q, y2_d;
    logic                 lds_q, lds_d;
    logic                 clipped_q, clipped_d;
    logic                 mode_q, mode_d;

    // Screen row of the incoming sample; two extra bits keep the subtraction exact.
    logic signed [DW-1:0] diff;
    logic                 clip_lo, clip_hi;
    logic [Y_WIDTH-1:0]   ys;

    always_comb begin
        diff    = Y_CENTER_S - $signed({{2{sample[SAMPLE_WIDTH-1]}}, sample});
        clip_lo = diff < 0;
        clip_hi = diff > Y_MAX_S;
        if (clip_lo)      ys = '0;
        else if (clip_hi) ys = Y_MAX;
        else              ys = diff[Y_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            xacc_q    <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            x2_q      <= '0;
            y2_q      <= '0;
            lds_q     <= 1'b0;
            clipped_q <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            xacc_q    <= xacc_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            x2_q      <= x2_d;
            y2_q      <= y2_d;
            lds_q     <= lds_d;
            clipped_q <= clipped_d;
            mode_q    <= mode_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        xacc_d    = xacc_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        x2_d      = x2_q;
        y2_d      = y2_q;
        lds_d     = 1'b0;
        clipped_d = clipped_q;
        mode_d    = mode_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FETCH;
                    k_d       = '0;
                    xacc_d    = '0;
                    clipped_d = 1'b0;
                    mode_d    = mode_points;
                end
            end
            FETCH: begin
                if (sample_valid) begin
                    if (clip_lo || clip_hi) clipped_d = 1'b1;
                    if (mode_q) begin
                        x1_d = xacc_q;
                        y1_d = ys;
                    end else begin
                        x1_d = x2_q;
                        y1_d = y2_q;
                    end
                    x2_d = xacc_q;
                    y2_d = ys;
                    // The first polyline point only primes the segment end.
                    if (!mode_q && k_q == '0) begin
                        k_d    = K_ONE;
                        xacc_d = xacc_q + X_INC;
                    end else begin
                        state_d = DRAW;
                    end
                end
            end
            DRAW: begin
                lds_d   = 1'b1;
                state_d = WAIT1;
            end
            WAIT1: state_d = WAIT2;
            WAIT2: begin
                if (line_drawer_ready) begin
                    if (k_q == K_LAST) begin
                        state_d = IDLE;
                        k_d     = '0;
                    end else begin
                        state_d = FETCH;
                        k_d     = k_q + K_ONE;
                        xacc_d  = xacc_q + X_INC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready             = (state_q == IDLE);
    assign sample_ready      = (state_q == FETCH);
    assign clipped           = clipped_q;
    assign x1                = x1_q;
    assign y1                = y1_q;
    assign x2                = x2_q;
    assign y2                = y2_q;
    assign line_drawer_start = lds_q;

endmodule
